// File: rtl/log_packetizer.sv
// Buffers fixed-size log records in a FIFO and serializes them MSB-first to a byte-wide
// serial sink, with an optional 4-byte tag per record and a lower-priority pass-through path.
module log_packetizer #(
    parameter int unsigned RECORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TAG_ENABLE   = 0,
    parameter logic [31:0] TAG          = 32'h52454144
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8*RECORD_BYTES-1:0]     rec_data,
    input  logic                          rec_strobe,
    input  logic [7:0]                    user_data,
    input  logic                          user_strobe,
    output logic                          user_ready,
    input  logic                          inhibit,
    input  logic                          uart_ready,
    output logic [7:0]                    uart_data,
    output logic                          uart_strobe,
    input  logic                          drop_clear,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned RW = 8 * RECORD_BYTES;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = RW + 32;
    localparam int unsigned IW = 3;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_BODY, S_USER} state_e;

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic [7:0]    drop_q;
    state_e        state_q;
    logic [SW-1:0] sh_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    data_q;
    logic          strobe_q;

    logic full_c, empty_c, push_c, drop_c, pop_c;

    // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
    assign full_c  = (level_q == LW'(FIFO_DEPTH));
    assign empty_c = (level_q == '0);
    assign push_c  = rec_strobe && !full_c;
    assign drop_c  = rec_strobe && full_c;
    assign pop_c   = (state_q == S_IDLE) && !empty_c && uart_ready;

    assign user_ready  = !reset && (state_q == S_IDLE) && empty_c && !inhibit && uart_ready;
    assign uart_data   = data_q;
    assign uart_strobe = strobe_q;
    assign drop_count  = drop_q;
    assign fifo_level  = level_q;

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q] <= rec_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push_c) wr_q <= wr_q + AW'(1);
            if (pop_c)  rd_q <= rd_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // A drop coinciding with a clear still leaves a count of one.
            if (drop_clear) begin
                drop_q <= drop_c ? 8'd1 : 8'd0;
            end else if (drop_c && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Serializer: shift register always emits its top byte; the tag is preloaded above the record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        sh_q    <= (TAG_ENABLE != 0) ? {TAG, mem_q[rd_q]} : {mem_q[rd_q], 32'h0};
                        idx_q   <= '0;
                        state_q <= (TAG_ENABLE != 0) ? S_TAG : S_BODY;
                    end else if (user_ready && user_strobe) begin
                        data_q   <= user_data;
                        strobe_q <= 1'b1;
                        state_q  <= S_USER;
                    end
                end
                S_TAG, S_BODY: begin
                    if (uart_ready) begin
                        data_q   <= sh_q[SW-1 -: 8];
                        strobe_q <= 1'b1;
                        sh_q     <= sh_q << 8;
                        idx_q    <= idx_q + IW'(1);
                        if (state_q == S_TAG && idx_q == IW'(3)) begin
                            state_q <= S_BODY;
                            idx_q   <= '0;
                        end else if (state_q == S_BODY && idx_q == IW'(RECORD_BYTES - 1)) begin
                            state_q <= S_IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
                S_USER: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_packetizer.sv
// Bench for log_packetizer: a small untagged/shallow instance and a tagged/deep instance,
// directed scenarios plus randomized record traffic checked against a byte-stream model.
module tb_log_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rec_data = '0;
    logic [7:0]  user_data = '0;
    logic        inhibit = 1'b0, uart_ready = 1'b1, drop_clear = 1'b0;
    logic        rs0 = 1'b0, rs1 = 1'b0, us0 = 1'b0, us1 = 1'b0;

    logic        ur0, ust0, ur1, ust1;
    logic [7:0]  ud0, dc0, ud1, dc1;
    logic [2:0]  lvl0;
    logic [4:0]  lvl1;

    always #5 clk = ~clk;

    log_packetizer #(.RECORD_BYTES(4), .FIFO_DEPTH(4), .TAG_ENABLE(0), .TAG(32'h52454144)) u0 (
        .clk(clk), .reset(reset), .rec_data(rec_data), .rec_strobe(rs0),
        .user_data(user_data), .user_strobe(us0), .user_ready(ur0), .inhibit(inhibit),
        .uart_ready(uart_ready), .uart_data(ud0), .uart_strobe(ust0),
        .drop_clear(drop_clear), .drop_count(dc0), .fifo_level(lvl0));

    log_packetizer #(.RECORD_BYTES(4), .FIFO_DEPTH(16), .TAG_ENABLE(1), .TAG(32'h52454144)) u1 (
        .clk(clk), .reset(reset), .rec_data(rec_data), .rec_strobe(rs1),
        .user_data(user_data), .user_strobe(us1), .user_ready(ur1), .inhibit(inhibit),
        .uart_ready(uart_ready), .uart_data(ud1), .uart_strobe(ust1),
        .drop_clear(drop_clear), .drop_count(dc1), .fifo_level(lvl1));

    typedef struct { int c; logic [7:0] b; } ev_t;
    ev_t  q0[$], q1[$];
    int   errors = 0, checks = 0, cyc = 0;
    logic rdy_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] rec, input int i);
        return rec[31-8*i -: 8];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Byte collector; every byte must follow a cycle in which the sink was ready.
    always @(negedge clk) begin
        if (ust0) begin
            q0.push_back('{cyc, ud0});
            chk("ready_before_byte_u0", 32'(rdy_prev), 32'd1);
        end
        if (ust1) begin
            q1.push_back('{cyc, ud1});
            chk("ready_before_byte_u1", 32'(rdy_prev), 32'd1);
        end
        rdy_prev = uart_ready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_bytes(input bit which, input int n, input int budget, input string tag);
        int k = 0;
        while (((which ? q1.size() : q0.size()) < n) && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(which ? q1.size() : q0.size()), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] recs[6];
        logic [7:0]  exp_q[$];
        logic [7:0]  tag_b[4];
        int t, k, seen, pushes;

        tag_b[0] = 8'h52; tag_b[1] = 8'h45; tag_b[2] = 8'h41; tag_b[3] = 8'h44;

        // Reset values
        step(3);
        chk("rst_strobe0", 32'(ust0), 0);
        chk("rst_data0",   32'(ud0), 0);
        chk("rst_uready0", 32'(ur0), 0);
        chk("rst_drop0",   32'(dc0), 0);
        chk("rst_level0",  32'(lvl0), 0);
        chk("rst_strobe1", 32'(ust1), 0);
        chk("rst_uready1", 32'(ur1), 0);
        chk("rst_level1",  32'(lvl1), 0);
        reset = 1'b0;
        step(2);

        // Single untagged record: latency 3, then back-to-back bytes
        q0.delete();
        t = cyc; rec_data = 32'h00001008; rs0 = 1'b1;
        step(1); rs0 = 1'b0;
        chk("level_after_push", 32'(lvl0), 1);
        wait_bytes(0, 4, 20, "basic_count");
        for (int i = 0; i < 4; i++) begin
            chk("basic_byte", 32'(q0[i].b), 32'(byte_of(32'h00001008, i)));
            chk("basic_time", 32'(q0[i].c), 32'(t + 3 + i));
        end

        // Overflow with sink stalled: 6 pushes into depth 4
        q0.delete();
        uart_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            recs[i] = $urandom; rec_data = recs[i]; rs0 = 1'b1;
            step(1);
        end
        rs0 = 1'b0; step(1);
        chk("ovf_level", 32'(lvl0), 4);
        chk("ovf_drops", 32'(dc0), 2);
        uart_ready = 1'b1;
        wait_bytes(0, 16, 80, "ovf_drain_count");
        step(10);
        chk("ovf_no_extra", 32'(q0.size()), 16);
        for (int i = 0; i < 16 && i < q0.size(); i++)
            chk("ovf_byte", 32'(q0[i].b), 32'(byte_of(recs[i/4], i%4)));
        drop_clear = 1'b1; step(1); drop_clear = 1'b0;
        chk("drop_clear", 32'(dc0), 0);

        // Saturation at 255, then clear coinciding with a drop
        uart_ready = 1'b0; rs0 = 1'b1;
        for (int i = 0; i < 264; i++) begin
            rec_data = $urandom; step(1);
        end
        rs0 = 1'b0; step(1);
        chk("drop_saturate", 32'(dc0), 255);
        rs0 = 1'b1; drop_clear = 1'b1; step(1);
        rs0 = 1'b0; drop_clear = 1'b0;
        chk("drop_clear_with_drop", 32'(dc0), 1);
        drop_clear = 1'b1; step(1); drop_clear = 1'b0;
        q0.delete(); uart_ready = 1'b1;
        wait_bytes(0, 16, 80, "sat_drain_count");
        step(3);
        chk("sat_drained_level", 32'(lvl0), 0);

        // Pass-through waits behind two records
        q0.delete();
        recs[0] = $urandom; recs[1] = $urandom;
        rec_data = recs[0]; rs0 = 1'b1; step(1);
        rec_data = recs[1]; step(1); rs0 = 1'b0;
        user_data = 8'hA5; us0 = 1'b1;
        k = 0;
        while (!ur0 && k < 100) begin step(1); k++; end
        chk("user_ready_after_records", 32'(q0.size()) + 32'(ust0), 8);
        step(1); us0 = 1'b0;
        wait_bytes(0, 9, 20, "user_count");
        step(5);
        chk("user_no_extra", 32'(q0.size()), 9);
        for (int i = 0; i < 8; i++)
            chk("user_rec_byte", 32'(q0[i].b), 32'(byte_of(recs[i/4], i%4)));
        chk("user_byte", 32'(q0[8].b), 32'h A5);
        chk("user_follows_last", 32'(q0[8].c), 32'(q0[7].c + 1));

        // Inhibit blocks pass-through
        q0.delete(); inhibit = 1'b1; us0 = 1'b1; seen = 0;
        repeat (20) begin step(1); if (ur0) seen++; end
        chk("inhibit_ready_seen", 32'(seen), 0);
        chk("inhibit_no_bytes", 32'(q0.size()), 0);
        inhibit = 1'b0; k = 0;
        while (!ur0 && k < 20) begin step(1); k++; end
        step(1); us0 = 1'b0;
        wait_bytes(0, 1, 10, "uninhibit_count");
        chk("uninhibit_byte", 32'(q0[0].b), 32'hA5);

        // Tagged record on u1
        q1.delete();
        t = cyc; rec_data = 32'h12345604; rs1 = 1'b1;
        step(1); rs1 = 1'b0;
        wait_bytes(1, 8, 30, "tag_count");
        for (int i = 0; i < 8; i++) begin
            chk("tag_byte", 32'(q1[i].b), 32'(i < 4 ? tag_b[i] : byte_of(32'h12345604, i - 4)));
            chk("tag_time", 32'(q1[i].c), 32'(t + 3 + i));
        end

        // Toggling sink readiness
        q0.delete(); recs[0] = $urandom; rec_data = recs[0];
        for (int i = 0; i < 16; i++) begin
            uart_ready = (i % 2 == 0);
            rs0 = (i == 0);
            step(1);
        end
        uart_ready = 1'b1;
        wait_bytes(0, 4, 20, "toggle_count");
        step(5);
        chk("toggle_no_dup", 32'(q0.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("toggle_byte", 32'(q0[i].b), 32'(byte_of(recs[0], i)));

        // Reset mid-record discards current and buffered records
        q0.delete(); recs[0] = $urandom; recs[1] = $urandom;
        rec_data = recs[0]; rs0 = 1'b1; step(1);
        rec_data = recs[1]; step(1); rs0 = 1'b0;
        wait_bytes(0, 2, 20, "pre_reset_count");
        reset = 1'b1; step(2);
        chk("midrst_strobe", 32'(ust0), 0);
        chk("midrst_level",  32'(lvl0), 0);
        chk("midrst_drop",   32'(dc0), 0);
        reset = 1'b0; step(20);
        chk("midrst_no_more_bytes", 32'(q0.size()), 2);
        q0.delete(); recs[2] = $urandom;
        t = cyc; rec_data = recs[2]; rs0 = 1'b1; step(1); rs0 = 1'b0;
        wait_bytes(0, 4, 20, "post_reset_count");
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_byte", 32'(q0[i].b), 32'(byte_of(recs[2], i)));
            chk("post_reset_time", 32'(q0[i].c), 32'(t + 3 + i));
        end

        // Randomized tagged traffic against the byte-stream model
        for (int burst = 0; burst < 3; burst++) begin
            q1.delete(); exp_q.delete(); pushes = 0;
            for (int i = 0; i < 40; i++) begin
                uart_ready = ($urandom % 10) < 7;
                if (pushes < 12 && ($urandom % 2) == 1) begin
                    rec_data = $urandom; rs1 = 1'b1; pushes++;
                    for (int j = 0; j < 4; j++) exp_q.push_back(tag_b[j]);
                    for (int j = 0; j < 4; j++) exp_q.push_back(byte_of(rec_data, j));
                end else begin
                    rs1 = 1'b0;
                end
                step(1);
            end
            rs1 = 1'b0; uart_ready = 1'b1;
            wait_bytes(1, exp_q.size(), 400, "rand_count");
            step(3);
            chk("rand_no_extra", 32'(q1.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < q1.size(); i++)
                chk("rand_byte", 32'(q1[i].b), 32'(exp_q[i]));
        end
        chk("rand_final_level", 32'(lvl1), 0);
        chk("rand_final_drops", 32'(dc1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
